// File: rtl/uart_pkg.sv
// Shared types and constants for the configurable UART receiver.
package uart_pkg;

  typedef enum logic [1:0] {NONE, EVEN, ODD} parity_e;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} rx_state_e;

  localparam int MIN_DIV = 4;

  function automatic parity_e to_parity(input logic [1:0] mode);
    case (mode)
      2'b01:   return EVEN;
      2'b10:   return ODD;
      default: return NONE;
    endcase
  endfunction

endpackage

// File: rtl/uart_rx_cfg_if.sv
// Received-word hand-off: held word plus its error flags, valid/ready.
interface uart_rx_cfg_if #(
  parameter int DATA_BITS = 8
) ();
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 parity_err;
  logic                 framing_err;

  modport master (output rx_data, rx_valid, parity_err, framing_err, input rx_ready);
  modport slave  (input rx_data, rx_valid, parity_err, framing_err, output rx_ready);
endinterface

// File: rtl/uart_rx_sampler.sv
// Line synchroniser, bit-period counter and 3-sample majority vote.
// Vote result is valid on mid_strobe (counter at div/2+1); end_strobe marks div-1.
module uart_rx_sampler #(
  parameter int DIV_WIDTH   = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 rx,
  input  logic                 cnt_clr,
  input  logic [DIV_WIDTH-1:0] div,
  output logic                 rx_sync,
  output logic                 fall_edge,
  output logic                 mid_strobe,
  output logic                 bit_val,
  output logic                 end_strobe
);
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic [DIV_WIDTH-1:0]   r_cnt;
  logic                   r_s0;
  logic                   r_s1;
  logic [DIV_WIDTH-1:0]   w_half;

  assign w_half     = div >> 1;
  assign rx_sync    = r_sync[SYNC_STAGES-1];
  assign fall_edge  = r_prev & ~rx_sync;
  assign mid_strobe = (r_cnt == w_half + DIV_WIDTH'(1));
  assign end_strobe = (r_cnt == div - DIV_WIDTH'(1));
  assign bit_val    = (r_s0 & r_s1) | (r_s0 & rx_sync) | (r_s1 & rx_sync);

  // Idle-high line: synchroniser resets to 1 so reset release is not a start edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_sync <= '1;
      r_prev <= 1'b1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], rx};
      r_prev <= rx_sync;
    end
  end

  always_ff @(posedge clock) begin
    if (reset || cnt_clr || end_strobe) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + DIV_WIDTH'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_s0 <= 1'b1;
      r_s1 <= 1'b1;
    end else begin
      if (r_cnt == w_half - DIV_WIDTH'(1)) r_s0 <= rx_sync;
      if (r_cnt == w_half) r_s1 <= rx_sync;
    end
  end

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: frame FSM, parity/break checks, valid/ready output register.
// Word appears 1 cycle after the last stop vote; a frame finishing while a word is held and not taken is dropped (overrun).
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter int DIV_WIDTH   = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [DIV_WIDTH-1:0] clock_div,
  input  logic [1:0]           parity_mode,
  input  logic                 two_stop,
  input  logic                 rx,
  uart_rx_cfg_if.master        rx_out,
  output logic                 rx_done,
  output logic                 overrun_err,
  output logic                 break_det,
  output logic                 busy
);
  rx_state_e            r_state, w_next;
  logic [DIV_WIDTH-1:0] r_div;
  parity_e              r_par;
  logic                 r_two;
  logic [DATA_BITS-1:0] r_shift, r_data;
  logic [3:0]           r_bit_idx;
  logic                 r_stop_idx, r_par_bit, r_frm_acc;
  logic                 r_valid, r_perr, r_ferr, r_done, r_ovr, r_brk;
  logic                 w_rx_sync, w_fall, w_mid, w_bit, w_end;
  logic                 w_cnt_clr, w_latch, w_busy, w_brk_hit, w_done;
  logic                 w_data_last, w_break_cond, w_perr;

  uart_rx_sampler #(.DIV_WIDTH(DIV_WIDTH), .SYNC_STAGES(SYNC_STAGES)) u_sampler (
    .clock      (clock),
    .reset      (reset),
    .rx         (rx),
    .cnt_clr    (w_cnt_clr),
    .div        (r_div),
    .rx_sync    (w_rx_sync),
    .fall_edge  (w_fall),
    .mid_strobe (w_mid),
    .bit_val    (w_bit),
    .end_strobe (w_end)
  );

  // At the minimum divisor mid and end strobes coincide, so the last data bit is
  // recognised in the same cycle it is sampled.
  assign w_data_last  = (r_bit_idx == 4'(DATA_BITS)) ||
                        (w_mid && (r_bit_idx == 4'(DATA_BITS - 1)));
  assign w_break_cond = (r_shift == '0) && ((r_par == NONE) || !r_par_bit) && !w_bit;

  always_comb begin
    case (r_par)
      EVEN:    w_perr = r_par_bit ^ (^r_shift);
      ODD:     w_perr = ~(r_par_bit ^ (^r_shift));
      default: w_perr = 1'b0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:   if (w_fall) w_next = START;
      START:  if (w_mid && w_bit) w_next = IDLE;
              else if (w_end) w_next = DATA;
      DATA:   if (w_end && w_data_last) w_next = (r_par != NONE) ? PARITY : STOP;
      PARITY: if (w_end) w_next = STOP;
      STOP:   if (w_brk_hit) w_next = BREAK;
              else if (w_done) w_next = IDLE;
      BREAK:  if (w_end) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_busy    = (r_state != IDLE);
    w_latch   = (r_state == IDLE) && w_fall;
    // In BREAK the counter only advances while the line is high.
    w_cnt_clr = (r_state == IDLE) || ((r_state == BREAK) && !w_rx_sync);
    w_brk_hit = (r_state == STOP) && w_mid && !r_stop_idx && w_break_cond;
    w_done    = (r_state == STOP) && w_mid && !w_brk_hit && (r_stop_idx == r_two);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_div      <= DIV_WIDTH'(MIN_DIV);
      r_par      <= NONE;
      r_two      <= 1'b0;
      r_shift    <= '0;
      r_data     <= '0;
      r_bit_idx  <= '0;
      r_stop_idx <= 1'b0;
      r_par_bit  <= 1'b0;
      r_frm_acc  <= 1'b0;
      r_valid    <= 1'b0;
      r_perr     <= 1'b0;
      r_ferr     <= 1'b0;
      r_done     <= 1'b0;
      r_ovr      <= 1'b0;
      r_brk      <= 1'b0;
    end else begin
      r_done <= w_done;
      r_brk  <= w_brk_hit;
      r_ovr  <= 1'b0;
      if (w_latch) begin
        r_div      <= (clock_div < DIV_WIDTH'(MIN_DIV)) ? DIV_WIDTH'(MIN_DIV) : clock_div;
        r_par      <= to_parity(parity_mode);
        r_two      <= two_stop;
        r_bit_idx  <= '0;
        r_stop_idx <= 1'b0;
        r_par_bit  <= 1'b0;
        r_frm_acc  <= 1'b0;
      end
      if ((r_state == DATA) && w_mid) begin
        r_shift   <= {w_bit, r_shift[DATA_BITS-1:1]};
        r_bit_idx <= r_bit_idx + 4'd1;
      end
      if ((r_state == PARITY) && w_mid) r_par_bit <= w_bit;
      if ((r_state == STOP) && w_mid && !w_bit) r_frm_acc <= 1'b1;
      if ((r_state == STOP) && w_end) r_stop_idx <= 1'b1;
      if (w_done) begin
        if (!r_valid || rx_out.rx_ready) begin
          r_data  <= r_shift;
          r_perr  <= w_perr;
          r_ferr  <= r_frm_acc | ~w_bit;
          r_valid <= 1'b1;
        end else begin
          r_ovr <= 1'b1;
        end
      end else if (r_valid && rx_out.rx_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign rx_out.rx_data     = r_data;
  assign rx_out.rx_valid    = r_valid;
  assign rx_out.parity_err  = r_perr;
  assign rx_out.framing_err = r_ferr;
  assign rx_done            = r_done;
  assign overrun_err        = r_ovr;
  assign break_det          = r_brk;
  assign busy               = w_busy;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed frames into uart_rx_cfg; a negedge monitor checks each accepted word against a queue.
module tb_uart_rx_cfg;

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] clock_div;
  logic [1:0]  parity_mode;
  logic        two_stop;
  logic        rx;
  logic        rx_done, overrun_err, break_det, busy;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_done  = 0;
  int   n_ovr   = 0;
  int   n_brk   = 0;
  int   n_vld   = 0;

  uart_rx_cfg_if #(.DATA_BITS(8)) rxif ();

  uart_rx_cfg #(.DATA_BITS(8), .DIV_WIDTH(16), .SYNC_STAGES(2)) dut (
    .clock       (clk),
    .reset       (rst),
    .clock_div   (clock_div),
    .parity_mode (parity_mode),
    .two_stop    (two_stop),
    .rx          (rx),
    .rx_out      (rxif),
    .rx_done     (rx_done),
    .overrun_err (overrun_err),
    .break_det   (break_det),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [7:0] d, input logic pe, input logic fe);
    exp_t e;
    e.d = d; e.pe = pe; e.fe = fe;
    exp_q.push_back(e);
  endtask

  // Start bit, 8 data bits LSB first, optional parity, 1 or 2 stops.
  // glitch_bit >= 0 inverts that bit for one cycle near its centre.
  task automatic send_frame(input int div, input logic [7:0] d, input bit has_par,
                            input logic pbit, input int nstop, input logic s2,
                            input int glitch_bit);
    logic [11:0] bits;
    int n;
    bits = '1;
    n = 0;
    bits[n] = 1'b0; n++;
    for (int i = 0; i < 8; i++) begin bits[n] = d[i]; n++; end
    if (has_par) begin bits[n] = pbit; n++; end
    bits[n] = 1'b1; n++;
    if (nstop == 2) begin bits[n] = s2; n++; end
    for (int b = 0; b < n; b++) begin
      for (int c = 0; c < div; c++) begin
        rx = (b == glitch_bit && c == 17) ? ~bits[b] : bits[b];
        tick(1);
      end
    end
    rx = 1'b1;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (rx_done)     n_done++;
      if (overrun_err) n_ovr++;
      if (break_det)   n_brk++;
      if (rxif.rx_valid) n_vld++;
      if (rxif.rx_valid && rxif.rx_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_word: got 0x%0h, expected no word", rxif.rx_data);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("word_data", 32'(rxif.rx_data), 32'(e.d));
          chk("word_parity_err", 32'(rxif.parity_err), 32'(e.pe));
          chk("word_framing_err", 32'(rxif.framing_err), 32'(e.fe));
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, v0, o0, b0, waited;
    rx = 1'b1;
    clock_div = 16'd434;
    parity_mode = 2'b00;
    two_stop = 1'b0;
    rxif.rx_ready = 1'b1;
    tick(3);
    chk("reset_rx_valid", 32'(rxif.rx_valid), 0);
    chk("reset_rx_data", 32'(rxif.rx_data), 0);
    chk("reset_parity_err", 32'(rxif.parity_err), 0);
    chk("reset_framing_err", 32'(rxif.framing_err), 0);
    chk("reset_rx_done", 32'(rx_done), 0);
    chk("reset_overrun", 32'(overrun_err), 0);
    chk("reset_break", 32'(break_det), 0);
    chk("reset_busy", 32'(busy), 0);
    rst = 1'b0;
    tick(5);

    // 8N1 at div 434
    d0 = n_done; v0 = n_vld;
    push(8'h41, 1'b0, 1'b0);
    send_frame(434, 8'h41, 0, 1'b0, 1, 1'b1, -1);
    tick(20);
    chk("t1_done_pulses", 32'(n_done - d0), 1);
    chk("t1_valid_cycles", 32'(n_vld - v0), 1);
    chk("t1_drain", 32'(exp_q.size()), 0);

    // false start: low 100 cycles at div 434
    d0 = n_done; v0 = n_vld;
    rx = 1'b0;
    tick(50);
    chk("false_start_busy", 32'(busy), 1);
    tick(50);
    rx = 1'b1;
    waited = 0;
    while (busy && waited < 334) begin tick(1); waited++; end
    chk("false_start_busy_clear", 32'(busy), 0);
    tick(20);
    chk("false_start_no_done", 32'(n_done - d0), 0);
    chk("false_start_no_valid", 32'(n_vld - v0), 0);

    // parity at div 32
    clock_div = 16'd32;
    parity_mode = 2'b01;
    push(8'h44, 1'b1, 1'b0);
    send_frame(32, 8'h44, 1, 1'b1, 1, 1'b1, -1);
    tick(6);
    push(8'h07, 1'b0, 1'b0);
    send_frame(32, 8'h07, 1, 1'b1, 1, 1'b1, -1);
    tick(6);
    parity_mode = 2'b10;
    push(8'h44, 1'b0, 1'b0);
    send_frame(32, 8'h44, 1, 1'b1, 1, 1'b1, -1);
    tick(6);
    push(8'h41, 1'b1, 1'b0);
    send_frame(32, 8'h41, 1, 1'b0, 1, 1'b1, -1);
    tick(10);
    chk("parity_drain", 32'(exp_q.size()), 0);
    parity_mode = 2'b00;

    // single-cycle glitches at the vote point
    push(8'h41, 1'b0, 1'b0);
    send_frame(32, 8'h41, 0, 1'b0, 1, 1'b1, 1);
    tick(6);
    push(8'h41, 1'b0, 1'b0);
    send_frame(32, 8'h41, 0, 1'b0, 1, 1'b1, 3);
    tick(10);
    chk("glitch_drain", 32'(exp_q.size()), 0);

    // overrun
    rxif.rx_ready = 1'b0;
    d0 = n_done; o0 = n_ovr;
    push(8'h41, 1'b0, 1'b0);
    send_frame(32, 8'h41, 0, 1'b0, 1, 1'b1, -1);
    tick(6);
    send_frame(32, 8'h4D, 0, 1'b0, 1, 1'b1, -1);
    tick(10);
    chk("overrun_pulses", 32'(n_ovr - o0), 1);
    chk("overrun_done_pulses", 32'(n_done - d0), 2);
    chk("overrun_held_data", 32'(rxif.rx_data), 32'h41);
    chk("overrun_held_valid", 32'(rxif.rx_valid), 1);
    rxif.rx_ready = 1'b1;
    tick(1);
    rxif.rx_ready = 1'b0;
    chk("handoff_valid_low", 32'(rxif.rx_valid), 0);
    chk("overrun_drain", 32'(exp_q.size()), 0);
    rxif.rx_ready = 1'b1;
    tick(4);

    // break: 12 bit periods low
    b0 = n_brk; d0 = n_done; v0 = n_vld;
    rx = 1'b0;
    tick(12 * 32);
    rx = 1'b1;
    tick(3 * 32);
    chk("break_pulses", 32'(n_brk - b0), 1);
    chk("break_no_done", 32'(n_done - d0), 0);
    chk("break_no_valid", 32'(n_vld - v0), 0);
    chk("break_idle", 32'(busy), 0);
    push(8'h4D, 1'b0, 1'b0);
    send_frame(32, 8'h4D, 0, 1'b0, 1, 1'b1, -1);
    tick(10);
    chk("after_break_drain", 32'(exp_q.size()), 0);

    // two stop bits
    two_stop = 1'b1;
    push(8'h41, 1'b0, 1'b1);
    send_frame(32, 8'h41, 0, 1'b0, 2, 1'b0, -1);
    tick(40);
    push(8'h5A, 1'b0, 1'b0);
    send_frame(32, 8'h5A, 0, 1'b0, 2, 1'b1, -1);
    tick(10);
    two_stop = 1'b0;
    chk("two_stop_drain", 32'(exp_q.size()), 0);

    // reset mid-DATA
    rx = 1'b0; tick(32);
    rx = 1'b1; tick(32);
    rx = 1'b0; tick(10);
    chk("mid_data_busy", 32'(busy), 1);
    rst = 1'b1;
    rx = 1'b1;
    tick(2);
    chk("mid_reset_busy", 32'(busy), 0);
    chk("mid_reset_valid", 32'(rxif.rx_valid), 0);
    chk("mid_reset_data", 32'(rxif.rx_data), 0);
    chk("mid_reset_ferr", 32'(rxif.framing_err), 0);
    rst = 1'b0;
    tick(4);
    d0 = n_done;
    push(8'h41, 1'b0, 1'b0);
    send_frame(32, 8'h41, 0, 1'b0, 1, 1'b1, -1);
    tick(10);
    chk("after_reset_done", 32'(n_done - d0), 1);
    chk("after_reset_drain", 32'(exp_q.size()), 0);

    // divisor below minimum runs at 4 cycles per bit
    clock_div = 16'd2;
    push(8'h3C, 1'b0, 1'b0);
    send_frame(4, 8'h3C, 0, 1'b0, 1, 1'b1, -1);
    tick(20);
    chk("clamp_drain", 32'(exp_q.size()), 0);

    tick(10);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
